seq_divider: RTL



---
 rtl/seq_divider.sv | 108 ++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring sequential divider, signed/unsigned, start/done handshake
module seq_divider #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             out_en,
  output logic             error,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH-1:0] p;
  logic [CW-1:0]    cnt;
  logic             qsign, rsign, bz;

  logic [WIDTH:0]   p_shift;
  logic             ge;
  logic [WIDTH-1:0] p_sub, p_nxt, quot_nxt;
  logic             last_iter;

  // The dividend register doubles as the quotient register: quotient bits enter at the LSB.
  assign p_shift   = {p, dvd[WIDTH-1]};
  assign ge        = p_shift >= {1'b0, bmag};
  assign p_sub     = p_shift[WIDTH-1:0] - bmag;
  assign p_nxt     = ge ? p_sub : p_shift[WIDTH-1:0];
  assign quot_nxt  = {dvd[WIDTH-2:0], ge};
  assign last_iter = (cnt == CW'(WIDTH - 1));

  assign busy   = (state == LOAD) || (state == CALC);
  assign out_en = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_en) state_nxt = LOAD;
      LOAD: state_nxt = bz ? DONE : CALC;
      CALC: if (last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd   <= '0;
      bmag  <= '0;
      p     <= '0;
      cnt   <= '0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      bz    <= 1'b0;
      q     <= '0;
      r     <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_en) begin
            dvd   <= (signed_mode && a[WIDTH-1]) ? -a : a;
            bmag  <= (signed_mode && b[WIDTH-1]) ? -b : b;
            qsign <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_mode;
            rsign <= a[WIDTH-1] & signed_mode;
            bz    <= (b == '0);
            p     <= '0;
            cnt   <= '0;
          end
        end
        LOAD: begin
          // Re-applying the dividend sign to its magnitude restores the raw dividend.
          if (bz) begin
            q     <= '1;
            r     <= rsign ? -dvd : dvd;
            error <= 1'b1;
          end
        end
        CALC: begin
          p   <= p_nxt;
          dvd <= quot_nxt;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            q     <= qsign ? -quot_nxt : quot_nxt;
            r     <= rsign ? -p_nxt : p_nxt;
            error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
